// File: rtl/z16_fetch_unit.sv
// z16_fetch_unit: fetch PC, ROM addressing, prefetch queue with redirect/halt; optional Z16_FETCH_STATS_EN adds o_bubble_cnt
//   i_clk, i_rst (sync, active-high) | o_imem_addr/i_imem_instr: combinational ROM
//   o_instr/o_pc/o_valid/i_ready: queue head to decode | i_redirect/i_redirect_addr: flush+refetch | i_halt: stop fetching
//   o_bubble_cnt (Z16_FETCH_STATS_EN only): saturating count of non-halt cycles with no valid head
module z16_fetch_unit #(
  parameter int DEPTH = 4,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic [15:0] o_imem_addr,
  input  logic [15:0] i_imem_instr,
  output logic [15:0] o_instr,
  output logic [15:0] o_pc,
  output logic        o_valid,
  input  logic        i_ready,
  input  logic        i_redirect,
  input  logic [15:0] i_redirect_addr,
  input  logic        i_halt
`ifdef Z16_FETCH_STATS_EN
  ,
  output logic [15:0] o_bubble_cnt
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  logic [15:0] pc;
  logic [AW:0] count;
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [15:0] q_instr [DEPTH];
  logic [15:0] q_pc [DEPTH];
  logic pop, push;
  assign o_valid = count != '0;
  assign pop = o_valid && i_ready;
  // a pop frees a slot in the same cycle, so a full queue can still accept
  assign push = !i_halt && !i_redirect && (count != FULL || pop);
  assign o_imem_addr = pc;
  assign o_instr = o_valid ? q_instr[rd_ptr] : '0;
  assign o_pc = o_valid ? q_pc[rd_ptr] : '0;
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pc <= RESET_PC;
      count <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else if (i_redirect) begin
      pc <= i_redirect_addr & 16'hFFFE;
      count <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
        pc <= pc + 16'd2;
      end
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
  always_ff @(posedge i_clk) begin
    if (push && !i_rst) begin
      q_instr[wr_ptr] <= i_imem_instr;
      q_pc[wr_ptr] <= pc;
    end
  end
`ifdef Z16_FETCH_STATS_EN
  always_ff @(posedge i_clk) begin
    if (i_rst) o_bubble_cnt <= '0;
    else if (!o_valid && !i_halt && o_bubble_cnt != 16'hFFFF) o_bubble_cnt <= o_bubble_cnt + 16'd1;
  end
`endif
endmodule

// File: tb/tb_z16_fetch_unit.sv
// tb_z16_fetch_unit: randomized and directed checks of z16_fetch_unit against a queue-based model
module tb_z16_fetch_unit;
  localparam int DEPTH = 4;
  typedef struct packed {logic [15:0] pc; logic [15:0] instr;} ent_t;
  logic clk = 1'b0;
  logic rst = 1'b1, ready = 1'b0, redirect = 1'b0, halt = 1'b0;
  logic [15:0] redirect_addr = '0;
  logic [15:0] imem_addr, imem_instr, instr, pc;
  logic valid;
  logic [15:0] rom [64];
  ent_t q[$];
  logic [15:0] mpc;
  logic [15:0] mbub;
  logic known = 1'b0;
  int checks = 0, errors = 0;
`ifdef Z16_FETCH_STATS_EN
  logic [15:0] bubble;
`endif
  always #5 clk = ~clk;
  assign imem_instr = rom[imem_addr[6:1]];
  z16_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(16'h0000)) dut (
    .i_clk(clk), .i_rst(rst), .o_imem_addr(imem_addr), .i_imem_instr(imem_instr),
    .o_instr(instr), .o_pc(pc), .o_valid(valid), .i_ready(ready),
    .i_redirect(redirect), .i_redirect_addr(redirect_addr), .i_halt(halt)
`ifdef Z16_FETCH_STATS_EN
    , .o_bubble_cnt(bubble)
`endif
  );
  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h t=%0t", name, act, exp, $time);
    end
  endtask
  task automatic compare();
    if (!known) return;
    chk("valid", {15'd0, valid}, {15'd0, q.size() != 0});
    chk("pc", pc, q.size() != 0 ? q[0].pc : 16'h0000);
    chk("instr", instr, q.size() != 0 ? q[0].instr : 16'h0000);
    chk("imem_addr", imem_addr, mpc);
`ifdef Z16_FETCH_STATS_EN
    chk("bubble", bubble, mbub);
`endif
  endtask
  task automatic model_step();
    if (rst) begin
      q.delete();
      mpc = 16'h0000;
      mbub = 16'h0000;
      known = 1'b1;
      return;
    end
    if (q.size() == 0 && !halt && mbub != 16'hFFFF) mbub++;
    if (redirect) begin
      q.delete();
      mpc = redirect_addr & 16'hFFFE;
      return;
    end
    if (ready && q.size() != 0) void'(q.pop_front());
    if (!halt && q.size() < DEPTH) begin
      q.push_back('{pc: mpc, instr: rom[mpc[6:1]]});
      mpc = mpc + 16'd2;
    end
  endtask
  task automatic cyc(input logic r, input logic rdy, input logic red, input logic [15:0] ra, input logic h);
    rst = r; ready = rdy; redirect = red; redirect_addr = ra; halt = h;
    #1;
    compare();
    model_step();
    @(negedge clk);
  endtask
  initial begin
    for (int i = 0; i < 64; i++) rom[i] = 16'($urandom);
    rom[0] = 16'h0010; rom[1] = 16'h0020; rom[2] = 16'h0A19;
    @(negedge clk);
    // test 1: reset then stream
    cyc(1, 0, 0, 0, 0); cyc(1, 0, 0, 0, 0);
    chk("rst_valid", {15'd0, valid}, 16'd0);
    chk("rst_pc", pc, 16'h0000);
    chk("rst_instr", instr, 16'h0000);
    chk("rst_addr", imem_addr, 16'h0000);
    cyc(0, 1, 0, 0, 0);
    chk("first_valid", {15'd0, valid}, 16'd1);
    chk("first_pc", pc, 16'h0000);
    chk("first_instr", instr, 16'h0010);
    cyc(0, 1, 0, 0, 0);
    chk("second_pc", pc, 16'h0002);
    chk("second_instr", instr, 16'h0020);
    cyc(0, 1, 0, 0, 0);
    chk("third_instr", instr, 16'h0A19);
    for (int i = 0; i < 5; i++) cyc(0, 1, 0, 0, 0);
    // test 2: backpressure fills the queue
    cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) cyc(0, 0, 0, 0, 0);
    chk("full_addr", imem_addr, 16'h0008);
    chk("full_head", pc, 16'h0000);
    for (int i = 0; i < 6; i++) cyc(0, 1, 0, 0, 0);
    // test 3: redirect while full
    for (int i = 0; i < 6; i++) cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 1, 16'h0005, 0);
    chk("redir_flush", {15'd0, valid}, 16'd0);
    cyc(0, 0, 0, 0, 0);
    chk("redir_valid", {15'd0, valid}, 16'd1);
    chk("redir_pc", pc, 16'h0004);
    // test 4: halt drains then resumes
    cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 1, 0, 0, 1);
    chk("halt_empty", {15'd0, valid}, 16'd0);
    chk("halt_addr", imem_addr, 16'h0006);
    cyc(0, 1, 0, 0, 0);
    chk("resume_pc", pc, 16'h0006);
    // test 5: PC wrap
    cyc(0, 1, 1, 16'hFFFC, 0);
    cyc(0, 1, 0, 0, 0); chk("wrap0", pc, 16'hFFFC);
    cyc(0, 1, 0, 0, 0); chk("wrap1", pc, 16'hFFFE);
    cyc(0, 1, 0, 0, 0); chk("wrap2", pc, 16'h0000);
    cyc(0, 1, 0, 0, 0); chk("wrap3", pc, 16'h0002);
`ifdef Z16_FETCH_STATS_EN
    // test 6: bubble counter
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0); cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 1, 16'h0010, 0); cyc(0, 1, 0, 0, 0);
    chk("bubble_two", bubble, 16'd2);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 0);
    chk("bubble_hold", bubble, 16'd2);
`endif
    // randomized traffic
    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
          16'($urandom), $urandom_range(0, 7) == 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/z16_fetch_unit.md
Name: z16_fetch_unit

Overview:
Instruction fetch controller for the Z16 core. It owns the fetch PC and drives the address of the combinational 16-bit instruction ROM (byte address in, word-indexed internally, one word per cycle). Fetched words go into a small prefetch queue that feeds decode over a valid/ready handshake. It also handles branch/jump redirects and halt.

Parameters:
DEPTH, 4, prefetch queue entries; power of two, minimum 2.
RESET_PC, 16'h0000, fetch PC after reset; bit 0 must be 0.

Ports:
i_clk  input  1  core clock
i_rst  input  1  synchronous, active-high reset
o_imem_addr  output  16  byte address to instruction ROM; always equals the fetch PC
i_imem_instr  input  16  ROM data, combinational from o_imem_addr in the same cycle
o_instr  output  16  instruction at queue head; 16'h0000 when queue empty
o_pc  output  16  byte address of o_instr; 16'h0000 when queue empty
o_valid  output  1  queue head is valid
i_ready  input  1  decode accepts head this cycle
i_redirect  input  1  branch/jump taken; flush the queue and refetch
i_redirect_addr  input  16  redirect target byte address
i_halt  input  1  stop fetching; queue keeps draining

Behaviour:
- Single clock domain; all state updates on the rising edge of i_clk. i_rst is synchronous, active-high, and wins over every other input.
- Reset values:
  - fetch PC = RESET_PC, queue count = 0, read/write pointers = 0.
  - o_valid = 0, o_instr = 0, o_pc = 0, o_imem_addr = RESET_PC.
- Pop: occurs when o_valid && i_ready. The head pointer advances and count decrements.
- Push: occurs when !i_halt && !i_redirect && (count < DEPTH || pop).
  - {fetch PC, i_imem_instr} is written at the tail.
  - fetch PC advances by 2.
- When full with a simultaneous pop, push and pop both happen and count is unchanged.
- With no pop and a full queue, there is no push and fetch PC holds. o_imem_addr stays stable.
- Latency:
  - Reset release to first o_valid = 1 cycle. The edge after reset deasserts writes RESET_PC's word.
  - Sustained throughput = 1 instr/cycle while i_ready=1.
- Redirect (i_redirect=1, not in reset):
  - Any handshake (o_valid && i_ready) in the same cycle counts as a completed transfer.
  - Then all entries are flushed: count = 0, pointers reset to 0.
  - fetch PC <= {i_redirect_addr[15:1], 1'b0}; bit 0 is forced to zero.
  - No push that cycle. o_valid = 0 in the next cycle. The target word is enqueued at the following edge, so o_valid returns 2 cycles after redirect assertion.
- Halt: no push, fetch PC holds, pops continue. Redirect during halt still flushes and loads the PC.
- Wrap-around: fetch PC 16'hFFFE + 2 = 16'h0000, modulo 2^16, no flag. Queue pointers wrap modulo DEPTH.
- o_imem_addr is purely the registered fetch PC; no combinational path from i_redirect.
- Reset mid-stream discards all queued entries immediately. o_valid is 0 in the cycle following the reset edge.

Optional Feature:
Z16_FETCH_STATS_EN
- Defined:
  - Adds output o_bubble_cnt (16 bits), reset to 0.
  - Increments on every non-reset cycle with o_valid=0 && i_halt=0.
  - Saturates at 16'hFFFF and is never cleared except by reset.
- Not defined: port and counter are absent. Core behaviour is identical.

Test Plan:
1. Reset, then i_ready=1 for 8 cycles, ROM holding 16'h0010,16'h0020,16'h0A19,... -> o_valid rises 1 cycle after reset release; o_pc sequence 0,2,4,...; o_instr matches the ROM in order, one per cycle.
2. i_ready=0 for 6 cycles -> 4 entries queued (DEPTH=4), o_imem_addr holds 16'h0008. Then i_ready=1 -> pcs 0,2,4,6,8 delivered with no gap or duplicate.
3. Redirect with i_redirect_addr=16'h0005 while queue full -> o_valid=0 next cycle; o_pc=16'h0004 two cycles after assertion; stale entries never appear.
4. i_halt=1 with 3 entries queued and i_ready=1 -> 3 instrs delivered, then o_valid=0; fetch PC frozen. Release halt -> fetch resumes from the frozen PC.
5. Redirect to 16'hFFFC, i_ready=1 -> o_pc 16'hFFFC, 16'hFFFE, 16'h0000, 16'h0002.
6. Z16_FETCH_STATS_EN defined: reset plus one redirect, with no halt -> o_bubble_cnt = 2 (first post-reset cycle plus one flush cycle). Hold i_ready=0 -> count unchanged.
